// File: rtl/trivium_host_if.sv
// trivium_host_if: host-side sequencer for a bit-serial Trivium core.
// Serialises key/IV, waits for core init, then streams 32-bit words.
module trivium_host_if #(
   parameter int INIT_TIMEOUT = 4095
) (
   input  logic        clk_i,
   input  logic        n_rst_i,
   input  logic [79:0] key_i,
   input  logic [79:0] iv_i,
   input  logic        start_i,
   input  logic [31:0] din_i,
   input  logic        din_valid_i,
   output logic        din_ready_o,
   output logic [31:0] dout_o,
   output logic        dout_valid_o,
   input  logic        finish_i,
   output logic        busy_o,
   output logic        err_o,
   output logic        tv_dat_o,
   output logic        tv_get_dat_o,
   output logic        tv_ld_keys_o,
   output logic        tv_end_o,
   input  logic        tv_dat_i,
   input  logic        tv_ready_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY, S_IV, S_LOAD,
      S_WAIT, S_STREAM, S_WORD, S_END
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(INIT_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_nxt;
   logic [79:0] r_key;
   logic [79:0] r_iv;
   logic [31:0] r_word;
   logic [6:0]  r_cnt;
   logic [15:0] r_tmo;
   logic        r_err;
   logic        r_dv;
   logic        w_tmo_hit;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) r_state <= S_IDLE;
      else          r_state <= w_nxt;
   end

   always_comb begin
      w_nxt     = r_state;
      w_tmo_hit = 1'b0;
      unique case (r_state)
         S_IDLE:   if (start_i) w_nxt = S_KEY;
         S_KEY:    if (r_cnt == 7'd79) w_nxt = S_IV;
         S_IV:     if (r_cnt == 7'd79) w_nxt = S_LOAD;
         S_LOAD:   w_nxt = S_WAIT;
         S_WAIT: begin
            if (tv_ready_i) begin
               w_nxt = S_STREAM;
            end else if (r_tmo == TMO_LAST) begin
               w_tmo_hit = 1'b1;
               w_nxt     = S_IDLE;
            end
         end
         S_STREAM: begin
            if (din_valid_i)   w_nxt = S_WORD;
            else if (finish_i) w_nxt = S_END;
         end
         S_WORD:   if (r_cnt == 7'd31) w_nxt = S_STREAM;
         S_END:    w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   // r_word is reused: plaintext shifts out LSB-first while result bits fill from the top
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_key  <= '0;
         r_iv   <= '0;
         r_word <= '0;
         r_cnt  <= '0;
         r_tmo  <= '0;
         r_err  <= 1'b0;
         r_dv   <= 1'b0;
      end else begin
         r_dv <= 1'b0;
         if (r_state != w_nxt)    r_cnt <= '0;
         else if (r_cnt != 7'd79) r_cnt <= r_cnt + 7'd1;
         if (r_state != S_WAIT) r_tmo <= '0;
         else                   r_tmo <= r_tmo + 16'd1;
         unique case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_key <= key_i;
                  r_iv  <= iv_i;
                  r_err <= 1'b0;
               end
            end
            S_KEY:    r_key <= r_key >> 1;
            S_IV:     r_iv  <= r_iv >> 1;
            S_WAIT:   if (w_tmo_hit) r_err <= 1'b1;
            S_STREAM: if (din_valid_i) r_word <= din_i;
            S_WORD: begin
               r_word <= {tv_dat_i, r_word[31:1]};
               if (r_cnt == 7'd31) r_dv <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy_o       = (r_state != S_IDLE);
   assign din_ready_o  = (r_state == S_STREAM);
   assign dout_o       = r_word;
   assign dout_valid_o = r_dv;
   assign err_o        = r_err;
   assign tv_ld_keys_o = (r_state == S_LOAD);
   assign tv_end_o     = (r_state == S_END);
   assign tv_get_dat_o = (r_state == S_KEY) | (r_state == S_IV)
                       | (r_state == S_WORD);
   assign tv_dat_o     = ((r_state == S_KEY)  & r_key[0])
                       | ((r_state == S_IV)   & r_iv[0])
                       | ((r_state == S_WORD) & r_word[0]);

endmodule
